nand_counter: RTL and testbench

- Loadable up-counter and the first sequential stage after the combinational gate library.
- Bit 0 toggles through an inverter. Upper bits use a ripple-carry increment.
- Feeds the program-counter and timer paths of the processor; the 16-bit instance is the PC.
- Supports a synchronous store (load), a count enable, a terminal-count indication and a sticky overflow flag.

---
 rtl/nand_counter_dff_bit.sv | 22 ++
 rtl/nand_counter.sv | 61 ++++++
 tb/tb_nand_counter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/nand_counter_dff_bit.sv
// Single-bit D flip-flop with synchronous active-high reset.
// Storage element for every bit of nand_counter, including its overflow flag.
`ifndef NAND_COUNTER_DFF_BIT_SV
`define NAND_COUNTER_DFF_BIT_SV

module dff_bit #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) q <= RST_VAL;
    else     q <= d;
  end

endmodule

`endif

// File: rtl/nand_counter.sv
// Loadable ripple-carry up-counter with combinational terminal count and sticky overflow.
// The 16-bit instance is used as the processor program counter.
`ifndef NAND_COUNTER_SV
`define NAND_COUNTER_SV

module nand_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             st,
  input  logic             en,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] RST_Q   = '0;
  localparam logic             RST_OVF = 1'b0;

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] inc;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap;
  logic             ovf_nxt;

  // carry[i] is the AND of q[i-1:0]; bit 0 sees a constant 1 and so simply inverts
  assign carry[0] = 1'b1;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      assign inc[i]     = q[i] ^ carry[i];
      assign carry[i+1] = carry[i] & q[i];
      assign q_nxt[i]   = st ? x[i] : (en ? inc[i] : q[i]);

      dff_bit #(.RST_VAL(RST_Q[i])) u_q (
        .clk (clk),
        .rst (rst),
        .d   (q_nxt[i]),
        .q   (q[i])
      );
    end
  endgenerate

  // carry out of the MSB is high exactly when q is all ones
  assign wrap    = carry[WIDTH];
  assign tc      = wrap & en & ~st;
  assign ovf_nxt = ~st & (ovf | (en & wrap));

  dff_bit #(.RST_VAL(RST_OVF)) u_ovf (
    .clk (clk),
    .rst (rst),
    .d   (ovf_nxt),
    .q   (ovf)
  );

endmodule

`endif

// File: tb/tb_nand_counter.sv
// Self-checking bench for nand_counter: directed vector table, then random stimulus
// against an arithmetic reference model on a 16-bit and a 2-bit instance.
`timescale 1ns/1ps

module tb_nand_counter;

  logic        clk;
  logic        rst;
  logic        st;
  logic        en;
  logic [15:0] x;
  logic [15:0] q;
  logic        tc;
  logic        ovf;
  logic [1:0]  q2;
  logic        tc2;
  logic        ovf2;

  int n_cmp;
  int n_err;

  nand_counter #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .st  (st),
    .en  (en),
    .x   (x),
    .q   (q),
    .tc  (tc),
    .ovf (ovf)
  );

  nand_counter #(.WIDTH(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .st  (st),
    .en  (en),
    .x   (x[1:0]),
    .q   (q2),
    .tc  (tc2),
    .ovf (ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        st;
    logic        en;
    logic [15:0] x;
    logic        exp_tc;   // before the edge
    logic [15:0] exp_q;    // after the edge
    logic        exp_ovf;  // after the edge
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input string name, input logic r, input logic s, input logic e,
                              input logic [15:0] xv, input logic etc, input logic [15:0] eq,
                              input logic eo);
    vec_t v;
    v.name = name; v.rst = r; v.st = s; v.en = e; v.x = xv;
    v.exp_tc = etc; v.exp_q = eq; v.exp_ovf = eo;
    return v;
  endfunction

  // reference model state
  int unsigned m_q, m_q2;
  bit          m_ovf, m_ovf2;

  task automatic model_step(input bit r, input bit s, input bit e, input int unsigned xv,
                            input int unsigned modulus, inout int unsigned mq, inout bit mo);
    if (r) begin
      mq = 0; mo = 0;
    end else if (s) begin
      mq = xv % modulus; mo = 0;
    end else if (e) begin
      if (mq == modulus - 1) mo = 1;
      mq = (mq + 1) % modulus;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; st = 1'b0; en = 1'b0; x = '0;

    vecs.push_back(mk("reset0",      1, 1, 0, 16'hABCD, 0, 16'h0000, 0));
    vecs.push_back(mk("reset1",      1, 1, 0, 16'hABCD, 0, 16'h0000, 0));
    vecs.push_back(mk("count1",      0, 0, 1, 16'h0000, 0, 16'h0001, 0));
    vecs.push_back(mk("count2",      0, 0, 1, 16'h0000, 0, 16'h0002, 0));
    vecs.push_back(mk("count3",      0, 0, 1, 16'h0000, 0, 16'h0003, 0));
    vecs.push_back(mk("count4",      0, 0, 1, 16'h0000, 0, 16'h0004, 0));
    vecs.push_back(mk("count5",      0, 0, 1, 16'h0000, 0, 16'h0005, 0));
    vecs.push_back(mk("load_prio",   0, 1, 1, 16'h1234, 0, 16'h1234, 0));
    vecs.push_back(mk("inc_after",   0, 0, 1, 16'h0000, 0, 16'h1235, 0));
    vecs.push_back(mk("load_fffe",   0, 1, 0, 16'hFFFE, 0, 16'hFFFE, 0));
    vecs.push_back(mk("wrap_e1",     0, 0, 1, 16'h0000, 0, 16'hFFFF, 0));
    vecs.push_back(mk("wrap_e2",     0, 0, 1, 16'h0000, 1, 16'h0000, 1));
    vecs.push_back(mk("wrap_e3",     0, 0, 1, 16'h0000, 0, 16'h0001, 1));
    vecs.push_back(mk("hold1",       0, 0, 0, 16'h5A5A, 0, 16'h0001, 1));
    vecs.push_back(mk("hold2",       0, 0, 0, 16'hFFFF, 0, 16'h0001, 1));
    vecs.push_back(mk("hold3",       0, 0, 0, 16'h0F0F, 0, 16'h0001, 1));
    vecs.push_back(mk("sticky_clr",  0, 1, 0, 16'h0010, 0, 16'h0010, 0));
    vecs.push_back(mk("load_f0",     0, 1, 0, 16'h00F0, 0, 16'h00F0, 0));
    vecs.push_back(mk("cnt_f1",      0, 0, 1, 16'h0000, 0, 16'h00F1, 0));
    vecs.push_back(mk("mid_rst",     1, 1, 1, 16'h7777, 0, 16'h0000, 0));
    vecs.push_back(mk("resume1",     0, 0, 1, 16'h0000, 0, 16'h0001, 0));
    vecs.push_back(mk("resume2",     0, 0, 1, 16'h0000, 0, 16'h0002, 0));
    vecs.push_back(mk("load_ffff",   0, 1, 0, 16'hFFFF, 0, 16'hFFFF, 0));
    vecs.push_back(mk("ones_hold",   0, 0, 0, 16'h0000, 0, 16'hFFFF, 0));
    vecs.push_back(mk("ones_ld_en",  0, 1, 1, 16'h0005, 0, 16'h0005, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; st = vecs[i].st; en = vecs[i].en; x = vecs[i].x;
      #1;
      chk({vecs[i].name, ".tc"}, {31'b0, tc}, {31'b0, vecs[i].exp_tc});
      @(posedge clk);
      #1;
      chk({vecs[i].name, ".q"},   {16'b0, q},    {16'b0, vecs[i].exp_q});
      chk({vecs[i].name, ".ovf"}, {31'b0, ovf},  {31'b0, vecs[i].exp_ovf});
    end

    // Narrow instance: ovf stays set across repeated wraps, tc pulses every wrap
    @(negedge clk);
    rst = 1'b0; st = 1'b1; en = 1'b0; x = 16'h0003;
    @(posedge clk); #1;
    chk("w2.load", {30'b0, q2}, 32'd3);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      st = 1'b0; en = 1'b1;
      #1;
      chk("w2.tc", {31'b0, tc2}, {31'b0, (k % 4) == 0});
      @(posedge clk); #1;
      chk("w2.q",   {30'b0, q2},  (k + 4) % 4);
      chk("w2.ovf", {31'b0, ovf2}, 32'd1);
    end

    // Random phase: both instances against the model
    @(negedge clk);
    rst = 1'b1; st = 1'b0; en = 1'b0;
    @(posedge clk); #1;
    m_q = 0; m_ovf = 0; m_q2 = 0; m_ovf2 = 0;
    for (int n = 0; n < 600; n++) begin
      bit r, s, e;
      @(negedge clk);
      r = ($urandom_range(0, 39) == 0);
      s = ($urandom_range(0, 7) == 0);
      e = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) x = 16'hFFFC + 16'($urandom_range(0, 3));
      else                           x = 16'($urandom);
      rst = r; st = s; en = e;
      #1;
      chk("rnd.tc",  {31'b0, tc},  {31'b0, (!r || 1'b1) && m_q == 32'hFFFF && e && !s});
      chk("rnd.tc2", {31'b0, tc2}, {31'b0, m_q2 == 3 && e && !s});
      @(posedge clk); #1;
      model_step(r, s, e, x, 32'h10000, m_q, m_ovf);
      model_step(r, s, e, x, 4, m_q2, m_ovf2);
      chk("rnd.q",    {16'b0, q},    m_q);
      chk("rnd.ovf",  {31'b0, ovf},  {31'b0, m_ovf});
      chk("rnd.q2",   {30'b0, q2},   m_q2);
      chk("rnd.ovf2", {31'b0, ovf2}, {31'b0, m_ovf2});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
